// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, request op encoding,
// byte-lane enables and the byte-rotate helper used for unaligned word loads.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } lsuState_t;

   // Encoded as {req_load, req_byte}
   typedef enum logic [1:0] {
      OP_STR  = 2'b00,
      OP_STRB = 2'b01,
      OP_LDR  = 2'b10,
      OP_LDRB = 2'b11
   } lsuOp_t;

   localparam logic [3:0] BE_NONE  = 4'b0000;
   localparam logic [3:0] BE_BYTE0 = 4'b0001;
   localparam logic [3:0] BE_WORD  = 4'b1111;

   typedef struct packed {
      lsuOp_t      op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  rd;
   } lsuReq_t;

   function automatic logic [3:0] laneEnable(input logic [1:0] lane);
      return BE_BYTE0 << lane;
   endfunction

   function automatic logic [31:0] rotateRightBytes(input logic [31:0] word, input logic [1:0] lane);
      case (lane)
         2'd0:    return word;
         2'd1:    return {word[7:0], word[31:8]};
         2'd2:    return {word[15:0], word[31:16]};
         default: return {word[23:0], word[31:24]};
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request and writeback-side response handshakes of the load/store unit.
// slave is the unit itself; master is the pipeline (execute + writeback) around it.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_load;
   logic        req_byte;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_rd;
   logic        wb_valid;
   logic        wb_ready;
   logic        wb_we;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data;
   logic        fault;

   modport slave (
      input  req_valid, req_load, req_byte, req_addr, req_wdata, req_rd, wb_ready,
      output req_ready, wb_valid, wb_we, wb_rd, wb_data, fault
   );

   modport master (
      output req_valid, req_load, req_byte, req_addr, req_wdata, req_rd, wb_ready,
      input  req_ready, wb_valid, wb_we, wb_rd, wb_data, fault
   );
endinterface

// File: rtl/lsu_data_ram.sv
// Internal data RAM: MEM_WORDS x 32 bits, one-cycle synchronous read,
// per-byte write enables (bit n enables bits [8n+7:8n]).
module lsu_data_ram #(
   parameter int MEM_WORDS = 64
) (
   input  logic                         clk,
   input  logic                         rdEn,
   input  logic [$clog2(MEM_WORDS)-1:0] wordIdx,
   input  logic [3:0]                   byteEn,
   input  logic [31:0]                  wdata,
   output logic [31:0]                  rdata
);

   logic [31:0] mem [MEM_WORDS];

   // NOTE: no reset on the array or read register; a reset would turn the RAM into a flop bank and contents must survive reset anyway.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (byteEn[b]) begin
            mem[wordIdx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (rdEn) begin
         rdata <= mem[wordIdx];
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: LDR/STR/LDRB/STRB against an internal word RAM with
// valid/ready on both sides. Define LSU_UNALIGNED_ROTATE_EN for ARM7 rotated unaligned word loads.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 64
) (
   input logic  clk,
   input logic  nreset,
   lsu_if.slave bus
);

   localparam int          IDX_W      = $clog2(MEM_WORDS);
   localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

   lsuState_t   state;
   lsuState_t   nextState;
   lsuReq_t     req;
   logic [31:0] loadData;
   logic [31:0] alignedLoad;
   logic [31:0] ramRdata;
   logic [31:0] ramWdata;
   logic [3:0]  ramByteEn;
   logic        ramRdEn;
   logic        accept;
   logic        isLoad;
   logic        isByte;
   logic        inRange;
   logic [1:0]  lane;

   always_comb begin
      accept  = (state == IDLE) && bus.req_valid;
      isLoad  = (req.op == OP_LDR) || (req.op == OP_LDRB);
      isByte  = (req.op == OP_STRB) || (req.op == OP_LDRB);
      inRange = req.addr < ADDR_LIMIT;
      lane    = req.addr[1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (nreset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // NOTE: nextState gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (bus.req_valid) nextState = ACCESS;
         ACCESS:  nextState = isLoad ? WAIT : RESP;
         WAIT:    nextState = RESP;
         RESP:    if (bus.wb_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (nreset) begin
         req <= '0;
      end else if (accept) begin
         req <= '{op:    lsuOp_t'({bus.req_load, bus.req_byte}),
                  addr:  bus.req_addr,
                  wdata: bus.req_wdata,
                  rd:    bus.req_rd};
      end
   end

   // The RAM output register is valid throughout WAIT; capture the aligned result on the way out.
   always_ff @(posedge clk) begin
      if (nreset) begin
         loadData <= '0;
      end else if (state == WAIT) begin
         loadData <= alignedLoad;
      end
   end

   always_comb begin
      if (isByte) begin
         alignedLoad = {24'h0, ramRdata[{lane, 3'b000} +: 8]};
      end else begin
`ifdef LSU_UNALIGNED_ROTATE_EN
         alignedLoad = rotateRightBytes(ramRdata, lane);
`else
         alignedLoad = ramRdata;
`endif
      end
   end

   // A reset arriving while a store sits in ACCESS must cancel the write, hence the nreset term.
   always_comb begin
      ramRdEn   = (state == ACCESS) && isLoad;
      ramWdata  = isByte ? {4{req.wdata[7:0]}} : req.wdata;
      ramByteEn = BE_NONE;
      if ((state == ACCESS) && !isLoad && inRange && !nreset) begin
         ramByteEn = isByte ? laneEnable(lane) : BE_WORD;
      end
   end

   lsu_data_ram #(
      .MEM_WORDS(MEM_WORDS)
   ) uDataRam (
      .clk    (clk),
      .rdEn   (ramRdEn),
      .wordIdx(req.addr[2 +: IDX_W]),
      .byteEn (ramByteEn),
      .wdata  (ramWdata),
      .rdata  (ramRdata)
   );

   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.wb_valid  = (state == RESP);
      bus.wb_we     = (state == RESP) && isLoad && inRange;
      bus.wb_rd     = (state == RESP) ? req.rd : 4'h0;
      bus.wb_data   = ((state == RESP) && isLoad && inRange) ? loadData : 32'h0;
      bus.fault     = (state == RESP) && !inRange;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// traffic against a word-array memory model. Honours LSU_UNALIGNED_ROTATE_EN.
module tb_load_store_unit;

   localparam int MEM_WORDS = 64;

   typedef struct {
      logic [31:0] data;
      logic        we;
      logic [3:0]  rd;
      logic        fault;
      int          acceptEdge;
      int          latency;
   } expT;

   logic clk = 1'b0;
   logic nreset = 1'b1;
   always #5 clk = ~clk;

   lsu_if bus();

   load_store_unit #(
      .MEM_WORDS(MEM_WORDS)
   ) dut (
      .clk   (clk),
      .nreset(nreset),
      .bus   (bus.slave)
   );

   int          nChecks = 0;
   int          nFails = 0;
   int          edgeCount = 0;
   logic [31:0] model [MEM_WORDS];
   expT         expQ[$];
   bit          holdOff = 1'b0;
   bit          randReady = 1'b0;
   logic [31:0] lastData;
   logic        lastWe;
   logic        lastFault;
   logic [3:0]  lastRd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act !== req) begin
         nFails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic failNow(input string name);
      nChecks++;
      nFails++;
      $display("FAIL %s", name);
   endtask

   // Architectural effect of one operation on the model memory, and the response it must produce.
   function automatic expT modelOp(input bit load, input bit isByte, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] rd);
      expT   e;
      int    idx;
      int    sh;
      logic [31:0] w;
      e.rd      = rd;
      e.latency = load ? 3 : 2;
      e.data    = 32'h0;
      e.we      = 1'b0;
      e.fault   = !(addr < 32'(MEM_WORDS * 4));
      e.acceptEdge = 0;
      if (!e.fault) begin
         idx = int'(addr / 4);
         sh  = 8 * int'(addr % 4);
         w   = model[idx];
         if (load) begin
            e.we = 1'b1;
            if (isByte) begin
               e.data = (w >> sh) & 32'hFF;
            end else begin
`ifdef LSU_UNALIGNED_ROTATE_EN
               e.data = (sh == 0) ? w : ((w >> sh) | (w << (32 - sh)));
`else
               e.data = w;
`endif
            end
         end else if (isByte) begin
            model[idx] = (w & ~(32'hFF << sh)) | ({24'h0, wdata[7:0]} << sh);
         end else begin
            model[idx] = wdata;
         end
      end
      return e;
   endfunction

   task automatic waitIdle(output bit ok);
      int guard = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      ok = (bus.req_ready === 1'b1);
      if (!ok) failNow("req_ready timeout");
   endtask

   task automatic issue(input bit load, input bit isByte, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] rd);
      bit  ok;
      expT e;
      waitIdle(ok);
      if (!ok) return;
      bus.req_valid = 1'b1;
      bus.req_load  = load;
      bus.req_byte  = isByte;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_rd    = rd;
      e = modelOp(load, isByte, addr, wdata, rd);
      e.acceptEdge = edgeCount + 1;
      expQ.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_load  = 1'($urandom);
      bus.req_byte  = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_rd    = 4'($urandom);
   endtask

   task automatic waitDone();
      for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clk);
      if (expQ.size() != 0) failNow("response timeout");
   endtask

   initial begin
      bus.wb_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         bus.wb_ready = holdOff ? 1'b0 : (randReady ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   // Compare process: sampled 1 time unit after each rising edge.
   initial begin
      bit prevValid = 1'b0;
      bit frontSeen = 1'b0;
      expT e;
      forever begin
         @(posedge clk);
         #1;
         edgeCount++;
         if (nreset) begin
            prevValid = 1'b0;
            frontSeen = 1'b0;
         end else begin
            if (prevValid && bus.wb_ready && expQ.size() != 0) begin
               void'(expQ.pop_front());
               frontSeen = 1'b0;
            end
            if (bus.wb_valid) begin
               if (expQ.size() == 0) begin
                  failNow("unexpected wb_valid");
               end else begin
                  e = expQ[0];
                  if (!frontSeen) begin
                     // edges counted from the accept edge inclusive
                     check("latency", 32'(edgeCount - e.acceptEdge + 1), 32'(e.latency));
                  end
                  check("wb_data", bus.wb_data, e.data);
                  check("wb_we", 32'(bus.wb_we), 32'(e.we));
                  check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                  check("fault", 32'(bus.fault), 32'(e.fault));
                  check("req_ready in RESP", 32'(bus.req_ready), 32'd0);
                  lastData  = bus.wb_data;
                  lastWe    = bus.wb_we;
                  lastRd    = bus.wb_rd;
                  lastFault = bus.fault;
                  frontSeen = 1'b1;
               end
            end else if (frontSeen) begin
               failNow("wb_valid dropped before wb_ready");
               frontSeen = 1'b0;
            end
            prevValid = bus.wb_valid;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok;
      logic [31:0] savedWord;
      logic [31:0] addr;
      int          stallSeen;

      bus.req_valid = 1'b0;
      bus.req_load  = 1'b0;
      bus.req_byte  = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      bus.req_rd    = 4'h0;

      // 1: reset
      repeat (2) @(negedge clk);
      check("reset req_ready", 32'(bus.req_ready), 32'd1);
      check("reset wb_valid", 32'(bus.wb_valid), 32'd0);
      check("reset wb_we", 32'(bus.wb_we), 32'd0);
      check("reset fault", 32'(bus.fault), 32'd0);
      check("reset wb_data", bus.wb_data, 32'h0);
      check("reset wb_rd", 32'(bus.wb_rd), 32'd0);
      nreset = 1'b0;

      // RAM is not cleared by reset, so give every word a known value first.
      for (int i = 0; i < MEM_WORDS; i++) issue(1'b0, 1'b0, 32'(i * 4), $urandom, 4'h0);
      waitDone();

      // 2: word store then word load
      issue(1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 4'h5);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h3);
      waitDone();
      check("LDR 0x10", lastData, 32'hDEADBEEF);
      check("LDR rd", 32'(lastRd), 32'd3);
      check("LDR we", 32'(lastWe), 32'd1);

      // 3: byte store into lane 1, then word and byte loads
      issue(1'b0, 1'b1, 32'h11, 32'h123456AA, 4'h2);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h4);
      waitDone();
      check("LDR after STRB", lastData, 32'hDEADAAEF);
      issue(1'b1, 1'b1, 32'h13, 32'h0, 4'h6);
      waitDone();
      check("LDRB 0x13", lastData, 32'h000000DE);

      // 4: unaligned word load
      issue(1'b1, 1'b0, 32'h12, 32'h0, 4'h8);
      waitDone();
`ifdef LSU_UNALIGNED_ROTATE_EN
      check("LDR 0x12", lastData, 32'hAAEFDEAD);
`else
      check("LDR 0x12", lastData, 32'hDEADAAEF);
`endif

      // 5: writeback stall with a competing request on the input
      holdOff = 1'b1;
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h7);
      stallSeen = 0;
      for (int i = 0; i < 20 && bus.wb_valid !== 1'b1; i++) @(negedge clk);
      if (bus.wb_valid !== 1'b1) failNow("stall wb_valid timeout");
      for (int i = 0; i < 5; i++) begin
         bus.req_valid = 1'b1;
         bus.req_load  = 1'b0;
         bus.req_byte  = 1'b0;
         bus.req_addr  = 32'h0;
         bus.req_wdata = $urandom;
         @(negedge clk);
         check("stall req_ready", 32'(bus.req_ready), 32'd0);
         if (bus.wb_valid === 1'b1) stallSeen++;
      end
      bus.req_valid = 1'b0;
      check("stall cycles held", 32'(stallSeen), 32'd5);
      holdOff = 1'b0;
      waitDone();
      check("LDR after stall", lastData, 32'hDEADAAEF);

      // 6: out-of-range store, then reset-aborted store
      savedWord = model[0];
      issue(1'b0, 1'b0, 32'h100, 32'h12345678, 4'h9);
      waitDone();
      check("OOR fault", 32'(lastFault), 32'd1);
      check("OOR we", 32'(lastWe), 32'd0);
      issue(1'b1, 1'b0, 32'h0, 32'h0, 4'h1);
      waitDone();
      check("LDR 0x0 unchanged", lastData, savedWord);

      savedWord = model[8];
      waitIdle(ok);
      if (ok) begin
         bus.req_valid = 1'b1;
         bus.req_load  = 1'b0;
         bus.req_byte  = 1'b0;
         bus.req_addr  = 32'h20;
         bus.req_wdata = ~savedWord;
         @(negedge clk);
         bus.req_valid = 1'b0;
         nreset = 1'b1;
         @(negedge clk);
         nreset = 1'b0;
         check("abort req_ready", 32'(bus.req_ready), 32'd1);
         check("abort wb_valid", 32'(bus.wb_valid), 32'd0);
      end
      issue(1'b1, 1'b0, 32'h20, 32'h0, 4'hA);
      waitDone();
      check("LDR 0x20 after abort", lastData, savedWord);

      // Randomized traffic with random writeback back-pressure
      randReady = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h100;
         else addr = 32'($urandom_range(0, MEM_WORDS * 4 - 1));
         issue(1'($urandom), 1'($urandom), addr, $urandom, 4'($urandom));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      waitDone();
      randReady = 1'b0;

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
